// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Package  : rv32i_pkg
// Brief    : Shared encodings and helpers for the rv32i instruction prefetch path.
// Revision : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // Prefetch sequencer state encoding
    typedef logic [1:0] pf_state_t;
    localparam pf_state_t c_ST_IDLE    = 2'd0;
    localparam pf_state_t c_ST_FETCH   = 2'd1;
    localparam pf_state_t c_ST_DISCARD = 2'd2;
    localparam pf_state_t c_ST_HALT    = 2'd3;

    // Queue entry is {pc, instruction, fault}
    localparam int c_XLEN_DEF    = 32;
    localparam int c_ILEN_DEF    = 32;
    localparam int c_ENTRY_W_DEF = c_XLEN_DEF + c_ILEN_DEF + 1;

    // Low address bits forced on every fetch address
    localparam logic [1:0] c_WORD_ALIGN = 2'b00;

    function automatic int entry_width(input int xlen, input int ilen);
        return xlen + ilen + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32i_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_prefetch_fifo
// Brief    : Synchronous FIFO with flush, registered storage and head-data output.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_prefetch_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head_data
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];

    // Pop frees its slot in the same cycle, so push is legal when full if popping
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rv32i_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_prefetch_queue
// Brief    : Sequential instruction prefetcher feeding a DEPTH-entry decode queue.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_prefetch_queue
    import rv32i_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter int               ILEN        = 32,
    parameter logic [XLEN-1:0]  VTABLE_ADDR = {XLEN{1'b0}},
    parameter int               DEPTH       = 4
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            advance_i,
    input  logic            clear_i,
    input  logic            pc_write_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instruction_o,
    output logic            fault_o,
    output logic            imem_stb_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic            imem_err_i,
    input  logic [ILEN-1:0] imem_data_i
);

    localparam int c_ENTRY_W = entry_width(XLEN, ILEN);
    localparam int c_CNT_W   = $clog2(DEPTH) + 1;

    pf_state_t           r_state;
    pf_state_t           w_state_nxt;
    logic [XLEN-1:0]     r_fetch_pc;
    logic [XLEN-1:0]     w_fetch_pc_nxt;
    logic [XLEN-1:0]     r_bus_addr;
    logic [XLEN-1:0]     w_bus_addr_nxt;

    logic                w_push;
    logic [c_ENTRY_W-1:0] w_push_data;
    logic                w_pop;
    logic                w_flush;
    logic                w_full;
    logic                w_empty;
    logic [c_CNT_W-1:0]  w_count;
    logic [c_ENTRY_W-1:0] w_head;
    logic [XLEN-1:0]     w_head_pc;
    logic [XLEN-1:0]     w_target;
    logic [XLEN-1:0]     w_fetch_pc_inc;
    logic                w_resp;
    logic [c_CNT_W:0]    w_fill_after;
    logic                w_room_after;
    logic                w_unused_pc_lsb;

    rv32i_prefetch_fifo #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .push      (w_push),
        .pop       (w_pop),
        .flush     (w_flush),
        .push_data (w_push_data),
        .full      (w_full),
        .empty     (w_empty),
        .count     (w_count),
        .head_data (w_head)
    );

    assign w_head_pc     = w_head[c_ENTRY_W-1 -: XLEN];
    assign valid_o       = ~w_empty;
    assign pc_o          = w_head_pc;
    assign instruction_o = w_head[ILEN:1];
    assign fault_o       = w_head[0];

    assign imem_stb_o  = (r_state == c_ST_FETCH) || (r_state == c_ST_DISCARD);
    assign imem_addr_o = r_bus_addr;

    assign w_unused_pc_lsb = ^pc_i[1:0];
    assign w_flush         = pc_write_i | clear_i;
    assign w_resp          = imem_ack_i | imem_err_i;
    assign w_pop           = advance_i & ~w_empty & ~w_flush;
    assign w_fetch_pc_inc  = r_fetch_pc + XLEN'(4);

    // Replay restarts at the oldest unconsumed PC, or the pending fetch if none queued
    assign w_target = pc_write_i ? {pc_i[XLEN-1:2], c_WORD_ALIGN}
                    : (!w_empty  ? w_head_pc : r_fetch_pc);

    // Occupancy after this cycle's ack push and any pop; decides back-to-back issue
    assign w_fill_after = {1'b0, w_count} + {{c_CNT_W{1'b0}}, 1'b1} - {{c_CNT_W{1'b0}}, w_pop};
    assign w_room_after = (w_fill_after < (c_CNT_W + 1)'(DEPTH));

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        w_push_data    = {r_fetch_pc, imem_data_i, 1'b0};
        if (w_flush) begin
            w_fetch_pc_nxt = w_target;
        end
        case (r_state)
            c_ST_IDLE: begin
                if (w_flush || !w_full) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (w_flush) begin
                    w_state_nxt = w_resp ? c_ST_FETCH : c_ST_DISCARD;
                end else if (imem_err_i) begin
                    w_push      = 1'b1;
                    w_push_data = {r_fetch_pc, {ILEN{1'b0}}, 1'b1};
                    w_state_nxt = c_ST_HALT;
                end else if (imem_ack_i) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = w_fetch_pc_inc;
                    w_state_nxt    = w_room_after ? c_ST_FETCH : c_ST_IDLE;
                end
            end
            c_ST_DISCARD: begin
                if (w_resp) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_HALT: begin
                if (w_flush) begin
                    w_state_nxt = c_ST_FETCH;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // The stale request's address stays on the bus until it completes
    assign w_bus_addr_nxt = (w_state_nxt == c_ST_DISCARD) ? r_bus_addr : w_fetch_pc_nxt;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state    <= c_ST_IDLE;
            r_fetch_pc <= VTABLE_ADDR;
            r_bus_addr <= VTABLE_ADDR;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_bus_addr <= w_bus_addr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_prefetch_queue
// Brief    : Randomised scoreboard bench for rv32i_prefetch_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_prefetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] VT    = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic        advance_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        pc_write_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        imem_ack_i = 1'b0;
    logic        imem_err_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instruction_o;
    logic        fault_o;
    logic        imem_stb_o;
    logic [31:0] imem_addr_o;

    rv32i_prefetch_queue #(
        .XLEN        (32),
        .ILEN        (32),
        .VTABLE_ADDR (VT),
        .DEPTH       (DEPTH)
    ) dut (
        .clk_i         (clk_i),
        .reset_ni      (reset_ni),
        .advance_i     (advance_i),
        .clear_i       (clear_i),
        .pc_write_i    (pc_write_i),
        .pc_i          (pc_i),
        .valid_o       (valid_o),
        .pc_o          (pc_o),
        .instruction_o (instruction_o),
        .fault_o       (fault_o),
        .imem_stb_o    (imem_stb_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_err_i    (imem_err_i),
        .imem_data_i   (imem_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // ---------------- reference model / scoreboard ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        f;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] next_pc   = VT;
    logic [31:0] held_addr = VT;
    bit          halted     = 0;
    bit          discarding = 0;
    bit          exp_stb    = 0;
    int          n_pops     = 0;

    always @(negedge clk_i) begin
        if (!reset_ni) begin
            mq.delete();
            next_pc    = VT;
            halted     = 0;
            discarding = 0;
            exp_stb    = 0;
        end else begin
            int          sz0;
            bit          resp;
            logic [31:0] target;
            // compare DUT against the model state left by the last edge
            chk("valid", valid_o, mq.size() != 0);
            if (mq.size() != 0) begin
                chk("head_pc", pc_o, mq[0].pc);
                chk("head_ins", instruction_o, mq[0].ins);
                chk("head_fault", fault_o, mq[0].f);
            end
            chk("stb", imem_stb_o, exp_stb);
            if (exp_stb) begin
                chk("addr", imem_addr_o, discarding ? held_addr : next_pc);
                if (!discarding) chk("slot_reserved", mq.size() < DEPTH, 1);
            end
            assert (dut.u_fifo.count <= DEPTH) else begin
                n_errors++;
                $display("FAIL count_bound: actual=%0d expected<=%0d", dut.u_fifo.count, DEPTH);
            end
            // advance model for the coming edge
            resp = exp_stb && (imem_ack_i || imem_err_i);
            sz0  = mq.size();
            if (pc_write_i || clear_i) begin
                target = pc_write_i ? {pc_i[31:2], 2'b00} : (sz0 != 0 ? mq[0].pc : next_pc);
                if (exp_stb && !resp) begin
                    if (!discarding) held_addr = next_pc;
                    discarding = 1;
                end else begin
                    discarding = 0;
                end
                mq.delete();
                next_pc = target;
                halted  = 0;
                exp_stb = 1;
            end else begin
                if (advance_i && sz0 != 0) begin
                    void'(mq.pop_front());
                    n_pops++;
                end
                if (resp && discarding) begin
                    discarding = 0;
                    exp_stb    = 1;
                end else if (resp && imem_err_i) begin
                    mq.push_back('{pc: next_pc, ins: 32'h0, f: 1'b1});
                    halted  = 1;
                    exp_stb = 0;
                end else if (resp) begin
                    mq.push_back('{pc: next_pc, ins: mem_word(next_pc), f: 1'b0});
                    next_pc = next_pc + 32'd4;
                    exp_stb = (mq.size() < DEPTH);
                end else if (exp_stb) begin
                    exp_stb = 1;
                end else begin
                    exp_stb = !halted && (sz0 < DEPTH);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // am: 0 = no response, 1 = ack, 2 = error
    task automatic step(input bit adv, input bit pw, input logic [31:0] pc, input bit clr, input int am);
        advance_i   = adv;
        pc_write_i  = pw;
        pc_i        = pc;
        clear_i     = clr;
        imem_ack_i  = (am == 1) && (imem_stb_o || ($urandom_range(0, 9) == 0));
        imem_err_i  = (am == 2) && imem_stb_o;
        imem_data_i = imem_ack_i ? mem_word(imem_addr_o) : $urandom;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        reset_ni = 1'b0;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        reset_ni = 1'b1;
    endtask

    task automatic wait_addr(input logic [31:0] a);
        for (int i = 0; i < 20; i++) begin
            if (imem_stb_o && imem_addr_o == a) break;
            step(0, 0, 0, 0, 1);
        end
        chk("reach_addr", imem_stb_o && (imem_addr_o == a), 1);
    endtask

    initial begin
        int c0;
        @(posedge clk_i);
        #1;
        do_reset();

        // fill from reset with zero-wait bus and no consumption
        repeat (10) step(0, 0, 0, 0, 1);
        chk("fill_stb_low", imem_stb_o, 0);
        chk("fill_valid", valid_o, 1);
        chk("fill_head_pc", pc_o, 32'h0);
        chk("fill_head_ins", instruction_o, mem_word(32'h0));

        // sustained streaming
        repeat (10) step(1, 0, 0, 0, 1);
        c0 = n_pops;
        repeat (10) step(1, 0, 0, 0, 1);
        chk("throughput", n_pops - c0, 10);

        // redirect while request to 0x8 is stalled
        do_reset();
        wait_addr(32'h8);
        step(0, 1, 32'h103, 0, 0);
        chk("redir_flush", valid_o, 0);
        chk("redir_hold_stb", imem_stb_o, 1);
        chk("redir_hold_addr", imem_addr_o, 32'h8);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("redir_new_addr", imem_addr_o, 32'h100);
        step(0, 0, 0, 0, 1);
        chk("redir_first_pc", pc_o, 32'h100);

        // redirect coinciding with ack
        do_reset();
        wait_addr(32'h8);
        step(0, 1, 32'h200, 0, 1);
        chk("redir_ack_valid", valid_o, 0);
        chk("redir_ack_addr", imem_addr_o, 32'h200);
        step(0, 0, 0, 0, 1);
        chk("redir_ack_pc", pc_o, 32'h200);

        // bus error halts fetching
        do_reset();
        wait_addr(32'h8);
        step(0, 0, 0, 0, 2);
        chk("err_stb_low", imem_stb_o, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("err_pc", pc_o, 32'h8);
        chk("err_fault", fault_o, 1);
        repeat (3) step(0, 0, 0, 0, 1);
        chk("halt_stb_low", imem_stb_o, 0);
        step(0, 1, 32'h40, 0, 0);
        chk("resume_stb", imem_stb_o, 1);
        chk("resume_addr", imem_addr_o, 32'h40);

        // clear replays from head pc
        do_reset();
        step(0, 1, 32'h14, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        chk("clr_head", pc_o, 32'h14);
        step(0, 0, 0, 1, 0);
        chk("clr_empty", valid_o, 0);
        chk("clr_hold_addr", imem_addr_o, 32'h1C);
        step(0, 0, 0, 0, 1);
        chk("clr_refetch", imem_addr_o, 32'h14);

        // asynchronous reset mid-FETCH
        reset_ni = 1'b0;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_pc", pc_o, 0);
        chk("arst_ins", instruction_o, 0);
        chk("arst_fault", fault_o, 0);
        chk("arst_stb", imem_stb_o, 0);
        chk("arst_addr", imem_addr_o, VT);
        step(0, 0, 0, 0, 1);
        reset_ni = 1'b1;

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            int          r;
            int          am;
            logic [31:0] tgt;
            if ($urandom_range(0, 999) == 0) do_reset();
            r   = $urandom_range(0, 99);
            am  = (r < 55) ? 1 : ((r < 58) ? 2 : 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                               : ($urandom & 32'h0000_3FFF);
            step($urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3, tgt,
                 $urandom_range(0, 99) < 3, am);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_prefetch_queue.md
Name: rv32i_prefetch_queue

Overview:
Parametrised successor to the single-entry instruction prefetch stage. It fetches sequential 32-bit instruction words over an external handshaked instruction bus and buffers up to DEPTH {pc, instruction, fault} entries for the decode stage, which consumes them with a valid/advance handshake. It supports branch redirect with in-flight response discard, replay flush, and bus-error tagging. It sits between the program counter logic and decode in the rv32i pipe.

Parameters:
XLEN, 32, address/PC width
ILEN, 32, instruction width
VTABLE_ADDR, 32'h00000000, fetch address after reset
DEPTH, 4, queue entries; power of two, >= 2

Ports:
clk_i  input  1  clock, rising edge
reset_ni  input  1  asynchronous active-low reset
advance_i  input  1  decode consumes head entry (pop) when valid_o=1
clear_i  input  1  flush queue and in-flight fetch; replay from head PC
pc_write_i  input  1  redirect fetch to pc_i
pc_i  input  XLEN  redirect target; bits [1:0] ignored (treated as 0)
valid_o  output  1  head entry present
pc_o  output  XLEN  PC of head entry
instruction_o  output  ILEN  instruction of head entry
fault_o  output  1  head entry came from a bus error
imem_stb_o  output  1  bus request strobe
imem_addr_o  output  XLEN  bus word address, [1:0]=0
imem_ack_i  input  1  bus completion with data
imem_err_i  input  1  bus completion with error (data ignored)
imem_data_i  input  ILEN  read data, valid with ack

Behaviour:
- Reset (asynchronous, reset_ni=0): queue empty, state IDLE, fetch_pc=VTABLE_ADDR, valid_o=0, pc_o=0, instruction_o=0, fault_o=0, imem_stb_o=0, imem_addr_o=VTABLE_ADDR. Storage is cleared to 0. Reset mid-transaction abandons the bus cycle; a late ack after release is ignored because state is IDLE.
- Head outputs are driven combinationally from registered queue storage. valid_o = (count != 0).
- States: IDLE, FETCH, DISCARD, HALT.
- IDLE: if count < DEPTH and no redirect/clear this cycle -> FETCH next cycle with imem_stb_o=1 and imem_addr_o=fetch_pc.
- FETCH: imem_stb_o and imem_addr_o are held stable until ack or err. At most one outstanding request. A slot is reserved for it, so issue requires count < DEPTH at issue time.
- FETCH, ack: push {fetch_pc, imem_data_i, 0}; fetch_pc += 4 (mod 2^XLEN, wraps). If space remains after this cycle's push/pop, stay in FETCH with the new address, strobe held high (back-to-back, 1 word/cycle max). Otherwise go to IDLE.
- FETCH, err: push {fetch_pc, 0, 1}; go to HALT. HALT issues no requests until pc_write_i.
- Latency: ack at edge t -> valid_o=1 after edge t (same-cycle visibility after the register update). Minimum redirect-to-valid is 3 cycles with a zero-wait bus: redirect, strobe, ack.
- pc_write_i has priority over everything. The queue empties next cycle, the pop is ignored, and fetch_pc <= {pc_i[XLEN-1:2],2'b00}.
  - In FETCH with no ack/err this cycle: go to DISCARD. Strobe and old address are held until ack/err, the response is dropped, then go to FETCH at the new fetch_pc.
  - In FETCH with ack/err in the same cycle: the response is dropped and the next state is FETCH with the new address.
  - In IDLE or HALT: go to FETCH.
  - In DISCARD: stay in DISCARD with the updated target.
- clear_i (pc_write_i=0): same flush and in-flight handling as a redirect, with target = head pc if valid_o, else fetch_pc (the in-flight address if FETCH).
- Simultaneous push and pop: allowed at any count, including full (count unchanged). Pop with valid_o=0 is ignored. Count never exceeds DEPTH; the bench asserts this.
- Pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.

Decomposition:
- Shared package rv32i_pkg: state encoding (IDLE, FETCH, DISCARD, HALT), the entry struct/width constant (XLEN+ILEN+1), and the word-align mask.
- One sub-module: rv32i_prefetch_fifo. It is a synchronous FIFO with async active-low reset, parameters WIDTH and DEPTH, ports push, pop, flush, full, empty, count, and a head-data output.
- The top level holds the FSM, fetch_pc and the bus interface.

Test Plan:
- Reset release, zero-wait ack, advance_i=0 -> addresses 0x0,0x4,0x8,0xC issued back-to-back; strobe drops with count=4; head pc_o=0x0 with instruction=mem[0].
- Full queue, advance_i=1 every cycle, ack every cycle -> sustained 1 entry/cycle; pc_o sequence 0x0,0x4,0x8… with no gaps or duplicates; count stays constant.
- Redirect pc_i=0x103 while request to 0x8 is stalled 3 cycles -> strobe/address 0x8 held until ack; data dropped; next address 0x100; first valid entry pc_o=0x100.
- Redirect in the same cycle as ack -> the acked word never appears; next issued address is the target.
- imem_err_i on 0x8 -> entry pc_o=0x8 with fault_o=1; no further strobes; pc_write_i=0x40 resumes fetch at 0x40.
- clear_i with head pc 0x14 and 2 entries queued -> queue empty next cycle; refetch starts at 0x14. Also: reset_ni asserted mid-FETCH -> all outputs at reset values immediately, without waiting for a clock edge.
